// File: rtl/uwasic_onboarding_aryan_kashem_pkg.sv
// Shared constants for the SPI-controlled PWM output block: register map,
// frame geometry and PWM clock divider.
package uwasic_onboarding_aryan_kashem_pkg;

  localparam int NUM_REGS  = 5;
  localparam int CLK_DIV   = 13;
  localparam int CLK_CNT_W = $clog2(CLK_DIV);

  localparam int FRAME_W   = 16;
  localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
  localparam int ADDR_W    = 7;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

endpackage

// File: rtl/uwasic_onboarding_aryan_kashem_pwm_peripheral.sv
// Single shared PWM generator (period 256*CLK_DIV clocks) and the per-output
// mux choosing forced-low, forced-high or the PWM waveform.
module uwasic_onboarding_aryan_kashem_pwm_peripheral
  import uwasic_onboarding_aryan_kashem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] en_out_i,
  input  logic [15:0] en_pwm_i,
  input  logic [7:0]  duty_i,
  output logic [15:0] out_o
);

  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [7:0]           pwm_cnt_q, pwm_cnt_d;
  logic                 pwm;

  // Prescaler wrap advances the 8-bit PWM phase counter.
  always_comb begin
    clk_cnt_d = clk_cnt_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q;
    if (clk_cnt_q == CLK_CNT_W'(CLK_DIV - 1)) begin
      clk_cnt_d = '0;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Full-scale duty is special-cased so 0xFF really means always on.
  assign pwm   = (duty_i == 8'hFF) || (pwm_cnt_q < duty_i);
  assign out_o = en_out_i & (~en_pwm_i | {16{pwm}});

endmodule

// File: rtl/uwasic_onboarding_aryan_kashem_spi_peripheral.sv
// Write-only SPI mode-0 peripheral: synchronizes the pins, shifts in a
// 16-bit frame (R/W, 7-bit address, 8-bit data) and commits it to a small
// register file on the nCS rising edge.
module uwasic_onboarding_aryan_kashem_spi_peripheral
  import uwasic_onboarding_aryan_kashem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sclk_i,
  input  logic        copi_i,
  input  logic        ncs_i,
  output logic [15:0] en_out_o,
  output logic [15:0] en_pwm_o,
  output logic [7:0]  duty_o
);

  logic [1:0]           sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                 sclk_prev_q, ncs_prev_q;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           regs_q [NUM_REGS];

  logic                 sclk_rise, ncs_fall, ncs_rise;
  logic [ADDR_W-1:0]    frame_addr;
  logic [2:0]           wr_idx;
  logic                 wr_en;

  // Two-flop synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      copi_sync_q <= {copi_sync_q[0], copi_i};
      ncs_sync_q  <= {ncs_sync_q[0], ncs_i};
      sclk_prev_q <= sclk_sync_q[1];
      ncs_prev_q  <= ncs_sync_q[1];
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_sync_q[1] & ncs_prev_q;
  assign ncs_rise  = ncs_sync_q[1] & ~ncs_prev_q;

  // Frame start clears the shifter; bits past the 16th are dropped.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (ncs_fall) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (!ncs_sync_q[1] && sclk_rise &&
                 bit_cnt_q != BIT_CNT_W'(FRAME_W)) begin
      shift_d   = {shift_q[FRAME_W-2:0], copi_sync_q[1]};
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  // Shift state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign frame_addr = shift_q[FRAME_W-2 -: ADDR_W];
  assign wr_idx     = frame_addr[2:0];
  assign wr_en      = ncs_rise && (bit_cnt_q == BIT_CNT_W'(FRAME_W)) &&
                      shift_q[FRAME_W-1] &&
                      (frame_addr < ADDR_W'(NUM_REGS));

  // Register file: only complete, in-range write frames land here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= shift_q[7:0];
    end
  end

  assign en_out_o = {regs_q[ADDR_EN_OUT_HI], regs_q[ADDR_EN_OUT_LO]};
  assign en_pwm_o = {regs_q[ADDR_EN_PWM_HI], regs_q[ADDR_EN_PWM_LO]};
  assign duty_o   = regs_q[ADDR_DUTY];

endmodule

// File: rtl/uwasic_onboarding_aryan_kashem.sv
// TinyTapeout user top: SPI-loaded control registers driving 16 PWM-capable
// outputs. All bidirectional pins are permanently outputs.
module uwasic_onboarding_aryan_kashem
  import uwasic_onboarding_aryan_kashem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [15:0] en_out, en_pwm, outs;
  logic [7:0]  duty;
  logic        unused_ok;

  uwasic_onboarding_aryan_kashem_spi_peripheral u_spi (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sclk_i   (ui_in[0]),
    .copi_i   (ui_in[1]),
    .ncs_i    (ui_in[2]),
    .en_out_o (en_out),
    .en_pwm_o (en_pwm),
    .duty_o   (duty)
  );

  uwasic_onboarding_aryan_kashem_pwm_peripheral u_pwm (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_out_i (en_out),
    .en_pwm_i (en_pwm),
    .duty_i   (duty),
    .out_o    (outs)
  );

  assign uo_out    = outs[7:0];
  assign uio_out   = outs[15:8];
  assign uio_oe    = 8'hFF;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_aryan_kashem.sv
// Self-checking bench: SPI frames driven on the pins, outputs compared with
// a register-map model and with PWM duty/period measured in clock counts.
module tb_uwasic_onboarding_aryan_kashem;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model [5];

  localparam int PERIOD = 256 * 13;

  always #50 clk = ~clk;

  uwasic_onboarding_aryan_kashem dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference: a frame only lands if it carried at least 16 bits, is a
  // write and targets one of the five registers.
  function automatic void model_apply(input logic [15:0] w, input int nbits);
    int addr;
    addr = int'(w[14:8]);
    if (nbits >= 16 && w[15] && addr < 5) model[addr] = w[7:0];
  endfunction

  // Expected 16 outputs; known[i]=0 where the bit follows a mid-range PWM.
  function automatic logic [15:0] model_out(output logic [15:0] known);
    logic [15:0] eo, ep, r;
    eo = {model[1], model[0]};
    ep = {model[3], model[2]};
    r = '0;
    known = '1;
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])      r[i] = 1'b0;
      else if (!ep[i]) r[i] = 1'b1;
      else if (model[4] == 8'h00) r[i] = 1'b0;
      else if (model[4] == 8'hFF) r[i] = 1'b1;
      else known[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
  endfunction

  // Drives one frame of nbits (bits beyond 16 are random filler), SCLK = clk/6.
  task automatic spi_send(input logic [15:0] w, input int nbits);
    @(negedge clk);
    ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ui_in[1] = (i < 16) ? w[15-i] : 1'($urandom);
      repeat (3) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (3) @(negedge clk);
      ui_in[0] = 1'b0;
    end
    repeat (3) @(negedge clk);
    ui_in[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic count_high(output int h);
    h = 0;
    for (int n = 0; n < PERIOD; n++) begin
      @(negedge clk);
      if (uo_out[0]) h++;
    end
  endtask

  // Rising edge to rising edge on uo_out[0]; -1 if no edge within the budget.
  task automatic measure_period(output int p);
    logic last;
    bit found;
    p = -1;
    found = 0;
    @(negedge clk);
    last = uo_out[0];
    for (int n = 0; n < 2 * PERIOD && !found; n++) begin
      @(negedge clk);
      if (!last && uo_out[0]) found = 1;
      last = uo_out[0];
    end
    if (found) begin
      for (int n = 1; n <= 2 * PERIOD; n++) begin
        @(negedge clk);
        if (!last && uo_out[0]) begin
          p = n;
          break;
        end
        last = uo_out[0];
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ui_in = 8'b0000_0100;
    uio_in = 8'h00;
    ena = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_uo_out: got %h expected 00", uo_out);
    end
    vectors++;
    if (uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_uio_out: got %h expected 00", uio_out);
    end
    vectors++;
    if (uio_oe !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_uio_oe: got %h expected ff", uio_oe);
    end
  endtask

  task automatic test_write();
    spi_send(16'h80F0, 16);
    model_apply(16'h80F0, 16);
    vectors++;
    if (uo_out !== 8'hF0) begin
      miscompares++;
      $display("FAIL write_lo: got %h expected f0", uo_out);
    end
    spi_send(16'h81CC, 16);
    model_apply(16'h81CC, 16);
    vectors++;
    if (uio_out !== 8'hCC || uo_out !== 8'hF0) begin
      miscompares++;
      $display("FAIL write_hi: got %h_%h expected cc_f0", uio_out, uo_out);
    end
  endtask

  task automatic test_discard();
    logic [15:0] frames [3];
    int lens [3];
    frames = '{16'hB0AA, 16'h0055, 16'h8011};
    lens   = '{16, 16, 12};
    for (int k = 0; k < 3; k++) begin
      spi_send(frames[k], lens[k]);
      model_apply(frames[k], lens[k]);
      vectors++;
      if ({uio_out, uo_out} !== 16'hCCF0) begin
        miscompares++;
        $display("FAIL discard_%0d: got %h expected ccf0", k, {uio_out, uo_out});
      end
    end
  endtask

  task automatic test_pwm_freq();
    int p, h;
    spi_send(16'h8001, 16); model_apply(16'h8001, 16);
    spi_send(16'h8100, 16); model_apply(16'h8100, 16);
    spi_send(16'h8201, 16); model_apply(16'h8201, 16);
    spi_send(16'h8480, 16); model_apply(16'h8480, 16);
    measure_period(p);
    vectors++;
    if (p < PERIOD - 33 || p > PERIOD + 33) begin
      miscompares++;
      $display("FAIL pwm_period: got %0d clocks expected %0d +-33", p, PERIOD);
    end
    count_high(h);
    vectors++;
    if (h < PERIOD / 2 - 33 || h > PERIOD / 2 + 33) begin
      miscompares++;
      $display("FAIL pwm_duty50: got %0d high clocks expected %0d", h, PERIOD / 2);
    end
  endtask

  task automatic test_duty_corners();
    int h;
    spi_send(16'h8400, 16); model_apply(16'h8400, 16);
    count_high(h);
    vectors++;
    if (h != 0) begin
      miscompares++;
      $display("FAIL duty_00: got %0d high clocks expected 0", h);
    end
    spi_send(16'h84FF, 16); model_apply(16'h84FF, 16);
    count_high(h);
    vectors++;
    if (h != PERIOD) begin
      miscompares++;
      $display("FAIL duty_ff: got %0d high clocks expected %0d", h, PERIOD);
    end
    spi_send(16'h8440, 16); model_apply(16'h8440, 16);
    spi_send(16'h8200, 16); model_apply(16'h8200, 16);
    count_high(h);
    vectors++;
    if (h != PERIOD) begin
      miscompares++;
      $display("FAIL en_pwm_off: got %0d high clocks expected %0d", h, PERIOD);
    end
  endtask

  task automatic test_random_duty();
    int h, d;
    spi_send(16'h8001, 16); model_apply(16'h8001, 16);
    spi_send(16'h8201, 16); model_apply(16'h8201, 16);
    for (int k = 0; k < 4; k++) begin
      d = $urandom_range(1, 254);
      spi_send({8'h84, 8'(d)}, 16);
      model_apply({8'h84, 8'(d)}, 16);
      count_high(h);
      vectors++;
      if (h != d * 13) begin
        miscompares++;
        $display("FAIL duty_rand %02h: got %0d high clocks expected %0d", d, h, d * 13);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [15:0] w, exp_o, known, got;
    int nbits, sel;
    int lens [6];
    lens = '{16, 16, 16, 17, 12, 15};
    for (int k = 0; k < 30; k++) begin
      w[15]   = ($urandom_range(0, 3) != 0);
      w[14:8] = 7'($urandom_range(0, 6));
      sel     = $urandom_range(0, 2);
      w[7:0]  = 8'($urandom);
      if (w[14:8] == 7'd4) w[7:0] = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : w[7:0];
      nbits = lens[$urandom_range(0, 5)];
      spi_send(w, nbits);
      model_apply(w, nbits);
      exp_o = model_out(known);
      got = {uio_out, uo_out};
      vectors++;
      if ((got & known) !== (exp_o & known)) begin
        miscompares++;
        $display("FAIL rand_frame %0d (%h/%0d bits): got %h expected %h mask %h",
                 k, w, nbits, got, exp_o, known);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    spi_send(16'h80FF, 16); model_apply(16'h80FF, 16);
    spi_send(16'h81FF, 16); model_apply(16'h81FF, 16);
    spi_send(16'h820F, 16); model_apply(16'h820F, 16);
    spi_send(16'h8480, 16); model_apply(16'h8480, 16);
    w = 16'h8155;
    @(negedge clk);
    ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ui_in[1] = w[15-i];
      repeat (3) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (3) @(negedge clk);
      ui_in[0] = 1'b0;
    end
    #20;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_async: got %h_%h oe %h expected 00_00 oe ff",
               uio_out, uo_out, uio_oe);
    end
    @(negedge clk);
    ui_in = 8'b0000_0100;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    spi_send(16'h80FF, 16);
    model_apply(16'h80FF, 16);
    vectors++;
    if (uo_out !== 8'hFF || uio_out !== 8'h00) begin
      miscompares++;
      $display("FAIL after_reset_write: got %h_%h expected 00_ff", uio_out, uo_out);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_discard();
    test_pwm_freq();
    test_duty_corners();
    test_random_duty();
    test_random_frames();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uwasic_onboarding_aryan_kashem.md
Name: uwasic_onboarding_aryan_kashem

Overview:
Top-level user block in TinyTapeout wrapper form. It contains an SPI peripheral, write-only and SPI mode 0, that loads five 8-bit control registers. Those registers drive a single shared PWM generator (about 3 kHz at a 10 MHz clk) and gate 16 outputs: uo_out[7:0] and uio_out[7:0]. Each output is forced low, forced high, or follows the PWM waveform.

Parameters:
CLK_DIV, 13, system clocks per PWM counter step (PWM period = 256*CLK_DIV clocks = 3328; 10 MHz/3328 ≈ 3.005 kHz)
NUM_REGS, 5, number of writable registers (valid addresses 0x00..0x04)

Ports:
clk  input  1  system clock, 10 MHz nominal
rst_n  input  1  asynchronous active-low reset
ena  input  1  design-selected flag; ignored
ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused
uo_out  output  8  outputs 0..7
uio_in  input  8  unused
uio_out  output  8  outputs 8..15
uio_oe  output  8  constant 8'hFF (all bidirectional pins are outputs)

Behaviour:
- Reset (rst_n=0, async): all registers, synchronizers, SPI shift state and PWM counters go to 0. Resulting outputs: uo_out=0, uio_out=0, uio_oe=8'hFF.
- Input sync: SCLK, COPI and nCS each pass through a 2-flop synchronizer on clk. Edge detection uses the synchronized SCLK (prev vs current).
- SPI frame: 16 bits, MSB first, COPI sampled on each synchronized SCLK rising edge while nCS=0.
  - bit15 = R/W (1=write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- SCLK must be ≤ clk/4 (max 2.5 MHz at 10 MHz clk).
- Frame start: nCS falling edge clears the bit counter and the shift register.
- Bit counting: the counter saturates at 16; extra bits beyond 16 are ignored.
- Commit: on the synchronized nCS rising edge, the data is written to reg[address], one clock after edge detection, only if all of the following hold:
  - exactly 16 bits were received;
  - R/W=1;
  - address ≤ 0x04.
- Discarded frames: anything else (short frame, read, address ≥ 0x05) is dropped with no side effect. There is no read-back path; COPI data never appears on any output.
- Register map:
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty[7:0]
- Reset mid-frame: the frame is aborted and registers are cleared.
- PWM timing: clk_cnt counts 0..CLK_DIV-1. On wrap, pwm_cnt (8-bit) increments, wrapping 255→0.
- PWM level: pwm = 1 if duty==8'hFF, else (pwm_cnt < duty).
  - duty=0 gives constant 0.
  - duty=0x80 gives a 50% duty cycle.
  - A duty update takes effect on the next clock compare (glitches allowed mid-period).
- Output mux, for bit i in 0..15: out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
  - uo_out = out[7:0], uio_out = out[15:8], both registered or combinational from registered state.
- Latency: the register takes effect within 4 clk cycles of the nCS rising edge at the pin.

Decomposition:
- Shared package: register address constants (ADDR_EN_OUT_LO=0x00 … ADDR_DUTY=0x04), NUM_REGS, CLK_DIV, and SPI frame width 16.
- Sub-module spi_peripheral: synchronizers, shift logic and register file. It exports the five registers.
- Sub-module pwm_peripheral: counters, compare and output mux.
- Top level: wiring only.

Test Plan:
- Reset, then idle → uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
- Write 0x00←0xF0 (frame 0x80F0), then write 0x01←0xCC (frame 0x81CC) → uo_out=0xF0, uio_out=0xCC.
- Invalid address 0x30←0xAA (frame 0xB0AA) → no change to any output. Read frame 0x0055 → ignored. A 12-bit truncated frame → ignored.
- Enable outputs and PWM: 0x00←0x01, 0x02←0x01, 0x04←0x80 → uo_out[0] ≈ 3.0 kHz (±1%), duty 50% (±1%).
- Duty corners: 0x04←0x00 → uo_out[0] constant 0. 0x04←0xFF → constant 1. en_pwm=0 with en_out=1 → constant 1.
- Assert rst_n=0 mid-frame and mid-PWM → all outputs 0 immediately (async). After release, a complete frame 0x80FF still works → uo_out=0xFF.
